// File: rtl/setting_entry.sv
// ----------------------------------------------------------------------------
// setting_entry
//   Operator-entry stage in front of the bottling controller. It synchronises
//   and debounces the three panel buttons and edits the BCD targets: pills per
//   bottle (000-999) and bottle count (00-99). It also drives the cursor
//   position, the flicker mask and the start/error strobes. Editing is only
//   possible while the controller reports SETTING (edit_en high).
//
//   Optional feature: define AUTOREPEAT_EN to build PULSE auto-repeat.
//
// Ports
//   clk_1khz        in   system clock, 1 kHz
//   rst_n           in   asynchronous active-low reset
//   btn_pulse       in   raw PULSE button, active-high (increment digit)
//   btn_start       in   raw QD button, active-high (request start)
//   btn_clr_raw     in   raw CLR button, active-LOW (short: next digit,
//                        long: clear all)
//   edit_en         in   high while controller is in SETTING
//   target_pills3   out  BCD hundreds of pills per bottle
//   target_pills2   out  BCD tens of pills per bottle
//   target_pills1   out  BCD units of pills per bottle
//   target_bottles2 out  BCD tens of bottle count
//   target_bottles1 out  BCD units of bottle count
//   position        out  cursor 0..4 (pills3, pills2, pills1, bottles2,
//                        bottles1)
//   flicker_mask    out  one-hot of position while editing, 0 otherwise
//   start_pulse     out  one cycle high: valid start accepted
//   err_pulse       out  one cycle high: start refused (zero target)
// ----------------------------------------------------------------------------
module setting_entry #(
    parameter int DEBOUNCE_CYC = 20,
    parameter int CLR_HOLD_CYC = 1000,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 200
) (
    input  logic       clk_1khz,
    input  logic       rst_n,
    input  logic       btn_pulse,
    input  logic       btn_start,
    input  logic       btn_clr_raw,
    input  logic       edit_en,
    output logic [3:0] target_pills3,
    output logic [3:0] target_pills2,
    output logic [3:0] target_pills1,
    output logic [3:0] target_bottles2,
    output logic [3:0] target_bottles1,
    output logic [2:0] position,
    output logic [4:0] flicker_mask,
    output logic       start_pulse,
    output logic       err_pulse
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYC);
    localparam int HOLD_W = $clog2(CLR_HOLD_CYC);

    // Button bit order inside the vectors below.
    localparam int B_PULSE = 0;
    localparam int B_START = 1;
    localparam int B_CLR   = 2;

    typedef enum logic [0:0] {
        ST_LOCKED = 1'b0,
        ST_EDIT   = 1'b1
    } state_t;

    // BCD increment with wrap; anything at or above 9 returns to 0 so a
    // digit register can never leave the 0..9 range.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        if (d >= 4'd9) begin
            return 4'd0;
        end else begin
            return d + 4'd1;
        end
    endfunction

    // Cursor position to flicker one-hot.
    function automatic logic [4:0] pos_onehot(input logic [2:0] p);
        case (p)
            3'd0:    return 5'b00001;
            3'd1:    return 5'b00010;
            3'd2:    return 5'b00100;
            3'd3:    return 5'b01000;
            3'd4:    return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    state_t state_r, state_nxt_s;

    logic [2:0]      sync1_r, sync2_r;
    logic [2:0]      smp_s;
    logic [2:0]      deb_r, deb_q_r;
    logic [DB_W-1:0] db_cnt_r [3];

    logic            pulse_press_s, start_press_s, clr_rel_s;
    logic            inc_s;

    logic [HOLD_W-1:0] hold_cnt_r;
    logic              long_done_r;
    logic              long_clr_s, short_clr_s;

    logic [3:0] dig_r   [5];
    logic [3:0] dig_nxt_s [5];
    logic [2:0] pos_r, pos_nxt_s;
    logic [4:0] mask_r, mask_nxt_s;
    logic       start_r, start_nxt_s;
    logic       err_r, err_nxt_s;
    logic       pills_nz_s, bottles_nz_s;

    // Two-stage synchronizer; CLR stages reset to the idle (high) raw level.
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 3'b100;
            sync2_r <= 3'b100;
        end else begin
            sync1_r <= {btn_clr_raw, btn_start, btn_pulse};
            sync2_r <= sync1_r;
        end
    end

    // CLR is active-low on the panel; everything downstream is active-high.
    assign smp_s = {~sync2_r[B_CLR], sync2_r[B_START], sync2_r[B_PULSE]};

    // Per-button debounce: count consecutive samples that disagree with the
    // debounced level, flip the level on the DEBOUNCE_CYC-th one.
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            deb_r   <= 3'b000;
            deb_q_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else begin
            deb_q_r <= deb_r;
            for (int i = 0; i < 3; i++) begin
                if (smp_s[i] == deb_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    db_cnt_r[i] <= '0;
                    deb_r[i]    <= smp_s[i];
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                end
            end
        end
    end

    assign pulse_press_s = deb_r[B_PULSE] & ~deb_q_r[B_PULSE];
    assign start_press_s = deb_r[B_START] & ~deb_q_r[B_START];
    assign clr_rel_s     = ~deb_r[B_CLR] & deb_q_r[B_CLR];

    // Long clear fires once per hold; a release after it is swallowed.
    assign long_clr_s  = (state_r == ST_EDIT) && edit_en && deb_r[B_CLR] &&
                         !long_done_r &&
                         (hold_cnt_r == HOLD_W'(CLR_HOLD_CYC - 1));
    assign short_clr_s = (state_r == ST_EDIT) && edit_en && clr_rel_s &&
                         !long_done_r;

    // CLR hold timer. Outside EDIT a held CLR is marked as consumed so that
    // its release after entering EDIT does not move the cursor.
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r  <= '0;
            long_done_r <= 1'b0;
        end else if ((state_r != ST_EDIT) || !edit_en) begin
            hold_cnt_r  <= '0;
            long_done_r <= deb_r[B_CLR];
        end else if (deb_r[B_CLR]) begin
            if (long_clr_s) begin
                hold_cnt_r  <= '0;
                long_done_r <= 1'b1;
            end else if (!long_done_r) begin
                hold_cnt_r  <= hold_cnt_r + HOLD_W'(1);
            end else begin
                hold_cnt_r  <= hold_cnt_r;
            end
        end else begin
            hold_cnt_r  <= '0;
            long_done_r <= 1'b0;
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt_r;
    logic             rep_phase_r;
    logic             rep_evt_s;

    // rep_cnt_r holds cycles since the press (phase 0) or since the last
    // repeat (phase 1); a repeat fires when it reaches the phase's period.
    always_comb begin
        rep_evt_s = 1'b0;
        if ((state_r == ST_EDIT) && edit_en && deb_r[B_PULSE] && !pulse_press_s) begin
            if (!rep_phase_r) begin
                rep_evt_s = (rep_cnt_r == REP_W'(REPEAT_DELAY));
            end else begin
                rep_evt_s = (rep_cnt_r == REP_W'(REPEAT_RATE));
            end
        end else begin
            rep_evt_s = 1'b0;
        end
    end

    // Auto-repeat timer, restarted by each press and each repeat.
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_r   <= '0;
            rep_phase_r <= 1'b0;
        end else if ((state_r != ST_EDIT) || !edit_en || !deb_r[B_PULSE]) begin
            rep_cnt_r   <= '0;
            rep_phase_r <= 1'b0;
        end else if (pulse_press_s) begin
            rep_cnt_r   <= REP_W'(1);
            rep_phase_r <= 1'b0;
        end else if (rep_evt_s) begin
            rep_cnt_r   <= REP_W'(1);
            rep_phase_r <= 1'b1;
        end else begin
            rep_cnt_r   <= rep_cnt_r + REP_W'(1);
        end
    end

    assign inc_s = pulse_press_s | rep_evt_s;
`else
    assign inc_s = pulse_press_s;
`endif

    assign pills_nz_s   = |{dig_r[0], dig_r[1], dig_r[2]};
    assign bottles_nz_s = |{dig_r[3], dig_r[4]};

    // FSM state register.
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_LOCKED;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_LOCKED: begin
                if (edit_en) begin
                    state_nxt_s = ST_EDIT;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            ST_EDIT: begin
                if (!edit_en) begin
                    state_nxt_s = ST_LOCKED;
                end else if (long_clr_s) begin
                    state_nxt_s = ST_EDIT;
                end else if (start_press_s && pills_nz_s && bottles_nz_s) begin
                    state_nxt_s = ST_LOCKED;
                end else begin
                    state_nxt_s = ST_EDIT;
                end
            end
            default: state_nxt_s = ST_LOCKED;
        endcase
    end

    // FSM output/datapath logic: one event per cycle in priority order
    // long-clear > START > PULSE > short-CLR; lower events are dropped.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            dig_nxt_s[i] = dig_r[i];
        end
        pos_nxt_s   = pos_r;
        start_nxt_s = 1'b0;
        err_nxt_s   = 1'b0;
        case (state_r)
            ST_LOCKED: begin
                pos_nxt_s = 3'd0;
            end
            ST_EDIT: begin
                if (!edit_en) begin
                    pos_nxt_s = 3'd0;
                end else if (long_clr_s) begin
                    for (int i = 0; i < 5; i++) begin
                        dig_nxt_s[i] = 4'd0;
                    end
                    pos_nxt_s = 3'd0;
                end else if (start_press_s) begin
                    if (pills_nz_s && bottles_nz_s) begin
                        start_nxt_s = 1'b1;
                        pos_nxt_s   = 3'd0;
                    end else begin
                        err_nxt_s   = 1'b1;
                    end
                end else if (inc_s) begin
                    for (int i = 0; i < 5; i++) begin
                        if (pos_r == 3'(i)) begin
                            dig_nxt_s[i] = bcd_inc(dig_r[i]);
                        end else begin
                            dig_nxt_s[i] = dig_r[i];
                        end
                    end
                end else if (short_clr_s) begin
                    if (pos_r >= 3'd4) begin
                        pos_nxt_s = 3'd0;
                    end else begin
                        pos_nxt_s = pos_r + 3'd1;
                    end
                end else begin
                    pos_nxt_s = pos_r;
                end
            end
            default: begin
                pos_nxt_s = 3'd0;
            end
        endcase

        if (state_nxt_s == ST_EDIT) begin
            mask_nxt_s = pos_onehot(pos_nxt_s);
        end else begin
            mask_nxt_s = 5'b00000;
        end
    end

    // Registered targets, cursor, mask and strobes.
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                dig_r[i] <= 4'd0;
            end
            pos_r   <= 3'd0;
            mask_r  <= 5'b00000;
            start_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                dig_r[i] <= dig_nxt_s[i];
            end
            pos_r   <= pos_nxt_s;
            mask_r  <= mask_nxt_s;
            start_r <= start_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    assign target_pills3   = dig_r[0];
    assign target_pills2   = dig_r[1];
    assign target_pills1   = dig_r[2];
    assign target_bottles2 = dig_r[3];
    assign target_bottles1 = dig_r[4];
    assign position        = pos_r;
    assign flicker_mask    = mask_r;
    assign start_pulse     = start_r;
    assign err_pulse       = err_r;

endmodule

// File: tb/tb_setting_entry.sv
// ----------------------------------------------------------------------------
// tb_setting_entry
//   Directed self-checking bench for setting_entry with default parameters
//   (debounce 20, long clear 1000). Inputs change 1 time unit after a rising
//   clock edge and outputs are checked at the same point.
// ----------------------------------------------------------------------------
module tb_setting_entry;

    logic       clk_1khz = 1'b0;
    logic       rst_n;
    logic       btn_pulse;
    logic       btn_start;
    logic       btn_clr_raw;
    logic       edit_en;
    logic [3:0] target_pills3, target_pills2, target_pills1;
    logic [3:0] target_bottles2, target_bottles1;
    logic [2:0] position;
    logic [4:0] flicker_mask;
    logic       start_pulse, err_pulse;

    int total = 0;
    int bad   = 0;

    setting_entry dut (
        .clk_1khz        (clk_1khz),
        .rst_n           (rst_n),
        .btn_pulse       (btn_pulse),
        .btn_start       (btn_start),
        .btn_clr_raw     (btn_clr_raw),
        .edit_en         (edit_en),
        .target_pills3   (target_pills3),
        .target_pills2   (target_pills2),
        .target_pills1   (target_pills1),
        .target_bottles2 (target_bottles2),
        .target_bottles1 (target_bottles1),
        .position        (position),
        .flicker_mask    (flicker_mask),
        .start_pulse     (start_pulse),
        .err_pulse       (err_pulse)
    );

    always #5 clk_1khz = ~clk_1khz;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_1khz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Clean press + release; 30 cycles covers sync + debounce + register.
    task automatic press_pulse(input int n);
        for (int i = 0; i < n; i++) begin
            btn_pulse = 1'b1; tick(30);
            btn_pulse = 1'b0; tick(30);
        end
    endtask

    task automatic press_clr(input int n);
        for (int i = 0; i < n; i++) begin
            btn_clr_raw = 1'b0; tick(30);
            btn_clr_raw = 1'b1; tick(30);
        end
    endtask

    initial begin
        rst_n = 1'b0; btn_pulse = 1'b0; btn_start = 1'b0;
        btn_clr_raw = 1'b1; edit_en = 1'b0;
        tick(3);
        chk("rst_pills3", target_pills3, 4'd0);
        chk("rst_bottles1", target_bottles1, 4'd0);
        chk("rst_pos", position, 3'd0);
        chk("rst_mask", flicker_mask, 5'b00000);
        chk("rst_pulses", {start_pulse, err_pulse}, 2'b00);
        rst_n = 1'b1; tick(5);
        chk("locked_mask", flicker_mask, 5'b00000);

        // Enter EDIT, three PULSE presses on pills3
        edit_en = 1'b1; tick(1);
        chk("edit_mask", flicker_mask, 5'b00001);
        press_pulse(3);
        chk("t1_pills3", target_pills3, 4'd3);
        chk("t1_pos", position, 3'd0);
        chk("t1_mask", flicker_mask, 5'b00001);

        // Exact press latency: action lands 23 edges after raw edge
        btn_pulse = 1'b1; tick(22);
        chk("lat_before", target_pills3, 4'd3);
        tick(1);
        chk("lat_at", target_pills3, 4'd4);
        btn_pulse = 1'b0; tick(30);
        press_pulse(5);
        chk("t2_pills3_9", target_pills3, 4'd9);

        // Cursor walk and pills2 edit
        press_clr(1);
        chk("t3_pos1", position, 3'd1);
        chk("t3_mask1", flicker_mask, 5'b00010);
        press_pulse(2);
        chk("t2_pills2", target_pills2, 4'd2);
        press_clr(3);
        chk("t3_pos4", position, 3'd4);
        chk("t3_mask4", flicker_mask, 5'b10000);
        press_clr(1);
        chk("t3_pos0", position, 3'd0);

        // 9 -> 0 wrap, no carry
        press_pulse(1);
        chk("t2_wrap", target_pills3, 4'd0);
        chk("t2_nocarry", target_pills2, 4'd2);

        // Long CLR: clear lands 1022 edges after raw edge
        press_clr(1);
        chk("t3_pos_pre_long", position, 3'd1);
        btn_clr_raw = 1'b0; tick(1021);
        chk("long_before", target_pills2, 4'd2);
        tick(1);
        chk("long_pills2", target_pills2, 4'd0);
        chk("long_pos", position, 3'd0);
        tick(100);
        btn_clr_raw = 1'b1; tick(30);
        chk("long_rel_pos", position, 3'd0);

        // Target 000/05 -> refused start
        press_clr(4);
        press_pulse(5);
        chk("t4_bottles1", target_bottles1, 4'd5);
        btn_start = 1'b1; tick(23);
        chk("t4_err", err_pulse, 1'b1);
        chk("t4_nostart", start_pulse, 1'b0);
        tick(1);
        chk("t4_err_1cyc", err_pulse, 1'b0);
        chk("t4_still_edit", flicker_mask, 5'b10000);
        btn_start = 1'b0; tick(30);

        // Pills 012 -> accepted start
        press_clr(2);
        press_pulse(1);
        press_clr(1);
        press_pulse(2);
        chk("t4_pills", {target_pills3, target_pills2, target_pills1}, 12'h012);
        btn_start = 1'b1; tick(23);
        edit_en = 1'b0;
        chk("t4_start", start_pulse, 1'b1);
        chk("t4_noerr", err_pulse, 1'b0);
        chk("t4_mask0", flicker_mask, 5'b00000);
        tick(1);
        chk("t4_start_1cyc", start_pulse, 1'b0);
        btn_start = 1'b0; tick(30);
        press_pulse(2);
        chk("t4_locked_pills1", target_pills1, 4'd2);
        chk("t4_locked_pos", position, 3'd0);

        // Bouncing PULSE then stable high -> one increment
        edit_en = 1'b1; tick(1);
        chk("t5_reenter", flicker_mask, 5'b00001);
        for (int i = 0; i < 10; i++) begin
            btn_pulse = ~btn_pulse; tick(5);
        end
        chk("t5_bounce_none", target_pills3, 4'd0);
        btn_pulse = 1'b1; tick(30);
        chk("t5_one_inc", target_pills3, 4'd1);
`ifdef AUTOREPEAT_EN
        tick(500);
        chk("t6_first_rep", target_pills3, 4'd2);
        tick(600);
        chk("t6_five_inc", target_pills3, 4'd5);
`else
        tick(600);
        chk("t5_held_no_rep", target_pills3, 4'd1);
`endif

        // Async reset mid-hold, checked before the next clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_digits",
            {target_pills3, target_pills2, target_pills1, target_bottles2, target_bottles1},
            20'h00000);
        chk("t5_async_pos", position, 3'd0);
        chk("t5_async_mask", flicker_mask, 5'b00000);
        tick(2);
        rst_n = 1'b1;
        btn_pulse = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
